fetch_stage: RTL

//  IF stage: PC register, instruction-memory request FSM, IF/ID pipeline register.

---
 rtl/arch_pkg.sv | 18 +
 rtl/if_id_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/arch_pkg.sv
// Shared architecture definitions for the pipeline front end.
//   ADDR_W_DEF / INSTR_W_DEF : default address and instruction widths
//   NOP_INSTR                : encoding used for pipeline bubbles
//   fetch_state_t            : fetch FSM states
package arch_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned INSTR_W_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst          : clock, asynchronous active-high reset
//   load              : capture {pc_in, instr_in, valid_in}
//   flush             : insert a bubble {0, NOP, 0}; wins over load
//   pc/instr/valid    : registered IF/ID slot contents
// With neither load nor flush the slot holds its value.
module if_id_reg
  import arch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               valid_in,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      instr <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      pc    <= '0;
      instr <= INSTR_W'(NOP_INSTR);
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= valid_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction-memory request FSM, skid buffer and
// IF/ID pipeline register.
//   clk, rst            : clock, asynchronous active-high reset
//   freeze              : hazard stall; holds PC and IF/ID
//   branch_taken/addr   : EXE redirect; flushes IF/ID, has priority over freeze
//   imem_req/addr       : fetch request (req registered), address stable until ready
//   imem_ready/rdata    : request accepted, rdata valid this cycle
//   if_pc/instr/valid   : IF/ID slot (if_pc = fetch address + 4)
// Optional macro FETCH_PERF_EN adds perf_stall_cnt / perf_fetch_cnt outputs.
module fetch_stage
  import arch_pkg::*;
#(
  parameter int unsigned           ADDR_W   = ADDR_W_DEF,
  parameter int unsigned           INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_fetch_cnt
`endif
);

  fetch_state_t       state, state_next;
  logic [ADDR_W-1:0]  pc, pc_next;
  logic [ADDR_W-1:0]  drop_addr;
  logic [INSTR_W-1:0] buf_instr;
  logic               buf_valid;
  logic               fire;

  logic               ifid_load, ifid_flush, ifid_from_buf;
  logic               buf_capture, buf_clear, drop_capture;
  logic [INSTR_W-1:0] ifid_instr_in;
  logic               ifid_valid_in;

  // A handshake only completes while a request is actually outstanding.
  assign fire = imem_req & imem_ready;

  // In DROP the PC already points at the branch target, so the abandoned
  // request keeps presenting its own address until memory accepts it.
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  // State register; imem_req is registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      imem_req <= 1'b0;
    end else begin
      state    <= state_next;
      imem_req <= (state_next != HOLD);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      FETCH: begin
        if (branch_taken) begin
          state_next = (imem_req && !imem_ready) ? DROP : FETCH;
        end else if (fire && freeze) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken || !freeze) state_next = FETCH;
      end
      DROP: begin
        if (fire) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Output / datapath control.
  always_comb begin
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_from_buf = 1'b0;
    buf_capture   = 1'b0;
    buf_clear     = 1'b0;
    drop_capture  = 1'b0;
    pc_next       = pc;
    if (branch_taken) begin
      ifid_flush   = 1'b1;
      buf_clear    = 1'b1;
      pc_next      = branch_addr;
      drop_capture = (state == FETCH) && imem_req && !imem_ready;
    end else begin
      unique case (state)
        FETCH: begin
          if (fire && !freeze) begin
            ifid_load = 1'b1;
            pc_next   = pc + ADDR_W'(4);
          end else if (fire && freeze) begin
            buf_capture = 1'b1;
          end else if (!freeze) begin
            ifid_flush = 1'b1;
          end
        end
        HOLD: begin
          if (!freeze) begin
            ifid_load     = 1'b1;
            ifid_from_buf = 1'b1;
            buf_clear     = 1'b1;
            pc_next       = pc + ADDR_W'(4);
          end
        end
        DROP: begin
          if (!freeze) ifid_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      drop_addr <= '0;
      buf_instr <= '0;
      buf_valid <= 1'b0;
    end else begin
      pc <= pc_next;
      if (drop_capture) drop_addr <= pc;
      if (buf_capture) begin
        buf_instr <= imem_rdata;
        buf_valid <= 1'b1;
      end else if (buf_clear) begin
        buf_instr <= '0;
        buf_valid <= 1'b0;
      end
    end
  end

  assign ifid_instr_in = ifid_from_buf ? buf_instr : imem_rdata;
  assign ifid_valid_in = ifid_from_buf ? buf_valid : 1'b1;

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .pc_in    (pc + ADDR_W'(4)),
    .instr_in (ifid_instr_in),
    .valid_in (ifid_valid_in),
    .pc       (if_pc),
    .instr    (if_instr),
    .valid    (if_valid)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_fetch_cnt <= '0;
    end else begin
      if (freeze) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (ifid_load && ifid_valid_in) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
    end
  end
`endif

endmodule
